// File: rtl/pancham_msg_driver.sv
// Packs a byte stream into pancham msg_in (byte 0 in the LSB), issues it, and streams the 16-byte digest back.
// Registered outputs. s_ready is low from message end until the digest completes. Digest bytes hold while d_ready=0.
module pancham_msg_driver #(
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [7:0]     s_data,
   input  logic           s_keep,
   input  logic           s_last,
   input  logic           s_valid,
   output logic           s_ready,
   output logic [0:127]   msg_in,
   output logic [0:7]     msg_in_width,
   output logic           msg_in_valid,
   input  logic [0:127]   msg_output,
   input  logic           msg_out_valid,
   input  logic           core_ready,
   output logic [7:0]     d_data,
   output logic           d_valid,
   output logic           d_last,
   input  logic           d_ready,
   output logic           err_overflow,
   output logic           err_timeout
);

   typedef enum logic [2:0] {IDLE, COLLECT, WAIT_RDY, ISSUE, WAIT_DIG, SEND} state_t;

   state_t        r_state;
   logic [4:0]    r_cnt;
   logic [3:0]    r_j;
   logic [31:0]   r_tcnt;
   logic [0:127]  r_cap;
   logic          r_first;
   logic          r_s_ready;
   logic [0:127]  r_msg;
   logic [0:7]    r_width;
   logic          r_miv;
   logic [7:0]    r_d_data;
   logic          r_d_valid;
   logic          r_d_last;
   logic          r_err_ov;
   logic          r_err_to;

   logic          w_accept;
   logic          w_store;
   logic [4:0]    w_cnt_nxt;
   logic [3:0]    w_slot;
   logic          w_timeout;
   logic          w_d_hs;
   logic          w_done;

   assign w_accept  = (r_state == COLLECT) & s_valid & r_s_ready;
   assign w_store   = w_accept & s_keep & ~r_cnt[4];
   assign w_cnt_nxt = w_store ? r_cnt + 5'd1 : r_cnt;
   assign w_slot    = 4'd15 - r_cnt[3:0];
   assign w_timeout = (TIMEOUT_CYC != 0) && (r_tcnt == 32'(TIMEOUT_CYC - 1));
   assign w_d_hs    = r_d_valid & d_ready;
   // Either the last digest byte handed off or the core never answered.
   assign w_done    = ((r_state == WAIT_DIG) & ~msg_out_valid & w_timeout) |
                      ((r_state == SEND) & w_d_hs & (r_j == 4'd15));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_j       <= '0;
         r_tcnt    <= '0;
         r_cap     <= '0;
         r_first   <= 1'b1;
         r_s_ready <= 1'b0;
         r_msg     <= '0;
         r_width   <= '0;
         r_miv     <= 1'b0;
         r_d_data  <= '0;
         r_d_valid <= 1'b0;
         r_d_last  <= 1'b0;
         r_err_ov  <= 1'b0;
         r_err_to  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_state   <= COLLECT;
               r_s_ready <= 1'b1;
            end
            COLLECT: begin
               if (w_accept) begin
                  if (r_first) begin
                     r_err_ov <= 1'b0;
                     r_err_to <= 1'b0;
                     r_first  <= 1'b0;
                  end
                  if (w_store)
                     r_msg[{w_slot, 3'b000} +: 8] <= s_data;
                  if (s_keep & r_cnt[4])
                     r_err_ov <= 1'b1;
                  r_cnt <= w_cnt_nxt;
                  if (s_last) begin
                     r_width   <= {w_cnt_nxt, 3'b000};
                     r_s_ready <= 1'b0;
                     r_state   <= WAIT_RDY;
                  end
               end
            end
            WAIT_RDY: begin
               if (core_ready) begin
                  r_miv   <= 1'b1;
                  r_state <= ISSUE;
               end
            end
            ISSUE: begin
               r_miv   <= 1'b0;
               r_tcnt  <= '0;
               r_state <= WAIT_DIG;
            end
            WAIT_DIG: begin
               if (msg_out_valid) begin
                  r_cap     <= msg_output << 8;
                  r_d_data  <= msg_output[0:7];
                  r_d_valid <= 1'b1;
                  r_d_last  <= 1'b0;
                  r_j       <= '0;
                  r_state   <= SEND;
               end else if (w_timeout) begin
                  r_err_to <= 1'b1;
               end else begin
                  r_tcnt <= r_tcnt + 32'd1;
               end
            end
            SEND: begin
               if (w_d_hs) begin
                  if (r_j == 4'd15) begin
                     r_d_valid <= 1'b0;
                     r_d_last  <= 1'b0;
                  end else begin
                     r_j      <= r_j + 4'd1;
                     r_d_data <= r_cap[0:7];
                     r_cap    <= r_cap << 8;
                     r_d_last <= (r_j == 4'd14);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
         if (w_done) begin
            r_state   <= COLLECT;
            r_s_ready <= 1'b1;
            r_cnt     <= '0;
            r_msg     <= '0;
            r_first   <= 1'b1;
         end
      end
   end

   assign s_ready      = r_s_ready;
   assign msg_in       = r_msg;
   assign msg_in_width = r_width;
   assign msg_in_valid = r_miv;
   assign d_data       = r_d_data;
   assign d_valid      = r_d_valid;
   assign d_last       = r_d_last;
   assign err_overflow = r_err_ov;
   assign err_timeout  = r_err_to;

endmodule

// File: tb/tb_pancham_msg_driver.sv
// Directed bench for pancham_msg_driver; the bench itself plays the pancham core.
module tb_pancham_msg_driver;
   localparam logic [127:0] DIG_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
   localparam logic [127:0] DIG_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
   localparam logic [127:0] DIG_MD    = 128'hf96b697d7cb7938d525a2f31aaf161d0;
   localparam logic [127:0] DIG_A     = 128'h0cc175b9c0f1b6a831c399e269772661;
   localparam logic [127:0] DIG_OVF   = 128'h0123456789abcdeffedcba9876543210;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    s_data;
   logic          s_keep, s_last, s_valid, s_ready;
   logic [127:0]  msg_in;
   logic [7:0]    msg_in_width;
   logic          msg_in_valid;
   logic [127:0]  msg_output;
   logic          msg_out_valid, core_ready;
   logic [7:0]    d_data;
   logic          d_valid, d_last, d_ready;
   logic          err_overflow, err_timeout;

   int            n_vec = 0;
   int            n_bad = 0;
   logic [7:0]    mb [0:31];

   pancham_msg_driver #(.TIMEOUT_CYC(8)) dut (
      .clk(clk), .reset(reset),
      .s_data(s_data), .s_keep(s_keep), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
      .msg_in(msg_in), .msg_in_width(msg_in_width), .msg_in_valid(msg_in_valid),
      .msg_output(msg_output), .msg_out_valid(msg_out_valid), .core_ready(core_ready),
      .d_data(d_data), .d_valid(d_valid), .d_last(d_last), .d_ready(d_ready),
      .err_overflow(err_overflow), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_str(input string s);
      for (int k = 0; k < s.len(); k++) mb[k] = s[k];
   endtask

   task automatic send_msg(input int n, input bit empty_last);
      int nb;
      int g;
      nb = empty_last ? n + 1 : n;
      for (int k = 0; k < nb; k++) begin
         s_valid = 1'b1;
         s_keep  = (k < n);
         s_data  = (k < n) ? mb[k] : 8'h00;
         s_last  = (k == nb - 1);
         g = 0;
         while (!s_ready && g < 100) begin
            tick();
            g++;
         end
         check("s_ready_seen", 128'(s_ready), 128'(1));
         tick();
      end
      s_valid = 1'b0;
      s_keep  = 1'b0;
      s_last  = 1'b0;
   endtask

   // Holds core_ready low for rdy_dly cycles (with a stray result pulse), then
   // releases it; a second stray pulse lands on the ISSUE cycle.
   task automatic issue(input logic [127:0] exp_msg, input logic [7:0] exp_w, input int rdy_dly);
      int g;
      for (int i = 0; i < rdy_dly; i++) begin
         check("miv_in_wait_rdy", 128'(msg_in_valid), 128'(0));
         msg_output    = '1;
         msg_out_valid = (i == 1);
         tick();
      end
      msg_out_valid = 1'b0;
      core_ready    = 1'b1;
      g = 0;
      while (!msg_in_valid && g < 50) begin
         tick();
         g++;
      end
      check("miv_seen", 128'(msg_in_valid), 128'(1));
      check("msg_in", msg_in, exp_msg);
      check("msg_in_width", 128'(msg_in_width), 128'(exp_w));
      core_ready    = 1'b0;
      msg_output    = '1;
      msg_out_valid = 1'b1;
      tick();
      msg_out_valid = 1'b0;
      msg_output    = '0;
      check("miv_one_cycle", 128'(msg_in_valid), 128'(0));
      check("d_valid_in_wait_dig", 128'(d_valid), 128'(0));
   endtask

   task automatic respond(input logic [127:0] w, input int lat);
      for (int i = 0; i < lat; i++) tick();
      msg_output    = w;
      msg_out_valid = 1'b1;
      tick();
      msg_out_valid = 1'b0;
      msg_output    = '0;
   endtask

   task automatic recv(input logic [127:0] exp, input bit stall, input int nbytes);
      int j;
      int c;
      int g;
      bit hs;
      logic [3:0] pat;
      j = 0; c = 0; g = 0;
      pat = 4'b1001;
      while (j < nbytes && g < 200) begin
         if (d_valid) begin
            check("d_data", 128'(d_data), 128'(exp[127 - 8*j -: 8]));
            check("d_last", 128'(d_last), 128'(j == 15));
         end
         d_ready = stall ? pat[c % 4] : 1'b1;
         c++;
         hs = d_valid & d_ready;
         tick();
         if (hs) j++;
         g++;
      end
      d_ready = 1'b0;
      check("digest_bytes", 128'(j), 128'(nbytes));
   endtask

   task automatic after_digest();
      check("d_valid_after", 128'(d_valid), 128'(0));
      check("s_ready_after", 128'(s_ready), 128'(1));
      d_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      d_ready = 1'b0;
      check("no_extra_byte", 128'(d_valid), 128'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      s_data = '0; s_keep = 1'b0; s_last = 1'b0; s_valid = 1'b0;
      msg_output = '0; msg_out_valid = 1'b0; core_ready = 1'b0; d_ready = 1'b0;
      #12;
      check("rst_outputs", 128'({s_ready, msg_in_valid, d_valid, d_last, err_overflow,
                                 err_timeout, d_data, msg_in_width}), 128'(0));
      check("rst_msg_in", msg_in, 128'h0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      check("s_ready_after_idle", 128'(s_ready), 128'(1));

      // Empty message
      send_msg(0, 1'b1);
      check("s_ready_drop", 128'(s_ready), 128'(0));
      check("empty_errs", 128'({err_overflow, err_timeout}), 128'(0));
      issue(128'h0, 8'h00, 3);
      respond(DIG_EMPTY, 2);
      recv(DIG_EMPTY, 1'b0, 16);
      after_digest();

      // "abc"
      load_str("abc");
      send_msg(3, 1'b0);
      issue(128'h636261, 8'h18, 0);
      respond(DIG_ABC, 3);
      recv(DIG_ABC, 1'b0, 16);
      after_digest();

      // 17 bytes: the 17th is dropped
      for (int k = 0; k < 17; k++) mb[k] = 8'(k + 1);
      send_msg(17, 1'b0);
      check("overflow_set", 128'(err_overflow), 128'(1));
      issue(128'h100f0e0d0c0b0a090807060504030201, 8'h80, 0);
      respond(DIG_OVF, 1);
      recv(DIG_OVF, 1'b0, 16);
      check("overflow_held", 128'(err_overflow), 128'(1));
      after_digest();

      // Core never answers
      mb[0] = 8'h5a;
      send_msg(1, 1'b0);
      check("overflow_cleared", 128'(err_overflow), 128'(0));
      issue(128'h5a, 8'h08, 0);
      for (int i = 0; i < 7; i++) tick();
      check("timeout_not_yet", 128'(err_timeout), 128'(0));
      tick();
      check("timeout_set", 128'(err_timeout), 128'(1));
      check("timeout_no_dvalid", 128'(d_valid), 128'(0));
      tick();
      check("timeout_s_ready", 128'(s_ready), 128'(1));
      check("timeout_msg_cleared", msg_in, 128'h0);

      // "message digest" with a stalling sink
      load_str("message digest");
      send_msg(14, 1'b0);
      check("timeout_cleared", 128'(err_timeout), 128'(0));
      issue(128'h74736567696420656761737365_6d, 8'h70, 0);
      respond(DIG_MD, 2);
      check("msg_in_hold", msg_in, 128'h74736567696420656761737365_6d);
      recv(DIG_MD, 1'b1, 16);
      after_digest();

      // Reset while presenting digest byte 5
      load_str("abc");
      send_msg(3, 1'b0);
      issue(128'h636261, 8'h18, 0);
      respond(DIG_ABC, 1);
      recv(DIG_ABC, 1'b0, 5);
      check("byte5_presented", 128'(d_data), 128'(8'hd2));
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_outputs", 128'({s_ready, msg_in_valid, d_valid, d_last, err_overflow,
                                       err_timeout, d_data, msg_in_width}), 128'(0));
      check("async_rst_msg_in", msg_in, 128'h0);
      @(negedge clk);
      reset = 1'b0;
      msg_output    = DIG_ABC;
      msg_out_valid = 1'b1;
      tick();
      msg_out_valid = 1'b0;
      msg_output    = '0;
      check("late_result_ignored", 128'(d_valid), 128'(0));

      load_str("a");
      send_msg(1, 1'b0);
      issue(128'h61, 8'h08, 0);
      respond(DIG_A, 1);
      recv(DIG_A, 1'b0, 16);
      after_digest();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/pancham_msg_driver.md
Name: pancham_msg_driver

Overview:
- Initiator-side adapter for the pancham MD5 core.
- Collects a byte stream (first byte first) into the core's 128-bit msg_in, with first byte in the least-significant byte, and sets msg_in_width.
- Issues the message when the core is ready, captures msg_output, and returns the digest as a 16-byte stream (digest byte 0 first).
- Sits between a host byte interface and one pancham instance.

Parameters:
TIMEOUT_CYC, 4096, cycles to wait in WAIT_DIG for msg_out_valid before aborting; 0 disables the timeout.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
s_data  in  8  input message byte
s_keep  in  1  1 = s_data is a valid byte; 0 allowed only with s_last (empty last beat)
s_last  in  1  final beat of message
s_valid  in  1  input beat valid
s_ready  out  1  input beat accepted when s_valid & s_ready
msg_in  out  128 [0:127]  to pancham msg_in
msg_in_width  out  8 [0:7]  to pancham msg_in_width, in bits
msg_in_valid  out  1  to pancham msg_in_valid
msg_output  in  128 [0:127]  from pancham msg_output
msg_out_valid  in  1  from pancham msg_out_valid
core_ready  in  1  from pancham ready
d_data  out  8  digest byte
d_valid  out  1  digest byte valid
d_last  out  1  marks digest byte 15
d_ready  in  1  digest sink accepts when d_valid & d_ready
err_overflow  out  1  message exceeded 16 bytes; held until next message's first accepted beat
err_timeout  out  1  TIMEOUT_CYC expired; held until next message's first accepted beat

Behaviour:
- All outputs registered. Reset values: all outputs 0, msg_in 0, byte count 0, state IDLE.
- States:
  - IDLE -> COLLECT unconditionally on the next edge.
  - COLLECT: s_ready=1.
    - Accepted beat with s_keep=1 and count<16: byte k goes to msg_in[120-8k +: 8] (bits 120-8k..127-8k in [0:127] numbering), then count++.
    - Accepted beat with s_keep=1 and count==16: byte dropped, err_overflow set.
    - Accepted beat with s_last: go to WAIT_RDY, msg_in_width=8*count (0..128), s_ready drops to 0 next cycle.
    - Unwritten msg_in bytes are 0; msg_in is cleared when a message completes.
  - WAIT_RDY: when core_ready=1, go to ISSUE.
  - ISSUE: msg_in_valid=1 for exactly one cycle, then WAIT_DIG.
  - WAIT_DIG:
    - On the first cycle msg_out_valid=1: capture msg_output, go to SEND.
    - msg_out_valid during ISSUE, or in any state other than WAIT_DIG, is ignored.
    - Timeout counter runs from WAIT_DIG entry. When it reaches TIMEOUT_CYC: set err_timeout, go to COLLECT, emit no digest.
  - SEND:
    - d_valid=1 with d_data = capture[8j +: 8] for j=0..15, i.e. byte 0 = msg_output[0:7].
    - j advances on d_valid & d_ready; d_last=1 when j=15.
    - d_data, d_valid, and d_last stay stable while d_ready=0.
    - After the byte-15 handshake: d_valid=0, count=0, go to COLLECT.
- msg_in and msg_in_width are held stable from WAIT_RDY entry until SEND exit.
- err_* are cleared by the first accepted s_valid beat of the next message.
- reset asserted in any state: asynchronous return to reset values. A core result arriving later is ignored (state is not WAIT_DIG).
- A single s_last & s_keep=1 beat is both the last byte and the message end.

Test Plan:
- Empty message (one beat s_last=1, s_keep=0), real pancham attached -> msg_in=0, msg_in_width=8'h00, one-cycle msg_in_valid; d_data stream d4 1d 8c d9 8f 00 b2 04 e9 80 09 98 ec f8 42 7e; d_last on byte 15.
- Bytes "a","b","c" (last on "c") -> msg_in=128'h636261 (in low bytes), msg_in_width=8'h18; digest 90 01 50 98 3c d2 4f b0 d6 96 3f 7d 28 e1 7f 72.
- "message digest" with d_ready toggling 1-0-0-1 -> width 8'h70; digest f9 6b 69 7d 7c b7 93 8d 52 5a 2f 31 aa f1 61 d0; d_data held stable while d_ready=0; exactly 16 handshakes.
- 17 bytes 0x01..0x11 -> err_overflow=1; msg_in_width=8'h80; msg_in holds 0x10..0x01 (0x11 dropped). Next message's first beat clears err_overflow.
- Stub core never asserts msg_out_valid, TIMEOUT_CYC=8 -> err_timeout=1 eight cycles after WAIT_DIG entry; s_ready=1 the next cycle; no d_valid.
- Assert reset during SEND at byte 5 -> all outputs 0 immediately. After release, "a" yields width 8'h08 and digest 0c c1 75 b9 c0 f1 b6 a8 31 c3 99 e2 69 77 26 61.
